// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the transmitter arbiter.
// Word width, default frame spacing and the arbiter state encoding.
package tx_arb_pkg;

    localparam int DATA_W               = 7;
    localparam int FRAME_CYCLES_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Index of the requester one past the current owner, wrapping at num_req.
    function automatic int rr_next(input int owner_idx, input int step, input int num_req);
        return (owner_idx + step) % num_req;
    endfunction

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Round-robin pick: first set req at or after owner+1 (wrapping); optional fixed priority for requester 0.
// Latency: combinational. Backpressure: none; the caller decides when the result is consumed.
module rr_pick
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter bit PRIO_EN = 1'b0,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   owner,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // Walk the search order backwards so the last hit written is the nearest one to owner+1.
    always_comb begin
        win_idx = '0;
        any     = |req;
        cand    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'(rr_next(int'(owner), k, NUM_REQ));
            if (req[cand]) begin
                win_idx = cand;
            end
        end
        if (PRIO_EN && req[0]) begin
            win_idx = '0;
        end
    end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter feeding one serial transmitter; TX_ARB_PRIORITY_EN makes requester 0 win whenever it asks.
// Latency: req to gnt/tx_start one clock from IDLE; back-to-back starts exactly FRAME_CYCLES apart.
// Backpressure: requesters hold req/req_data until their gnt pulse; no issue while a frame is in flight (busy).
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEFAULT,
    localparam int IDX_W       = $clog2(NUM_REQ),
    localparam int CNT_W       = $clog2(FRAME_CYCLES)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      busy,
    output logic [IDX_W-1:0]          owner
);

    if (FRAME_CYCLES < 10) begin : g_bad_frame
        $error("tx_arbiter: FRAME_CYCLES must be at least 10");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("tx_arbiter: NUM_REQ must be within 2..8");
    end

`ifdef TX_ARB_PRIORITY_EN
    localparam bit PRIO_EN = 1'b1;
`else
    localparam bit PRIO_EN = 1'b0;
`endif

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [NUM_REQ-1:0]  gnt_nxt;
    logic                start_nxt;
    logic [DATA_W-1:0]   data_nxt;
    logic                busy_nxt;
    logic [IDX_W-1:0]    owner_nxt;
    logic [IDX_W-1:0]    win_idx;
    logic                any;
    logic                arb;
    logic [DATA_W-1:0]   words [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign words[i] = req_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PRIO_EN (PRIO_EN)
    ) u_pick (
        .req     (req),
        .owner   (owner),
        .win_idx (win_idx),
        .any     (any)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt_nxt   = '0;
        start_nxt = 1'b0;
        data_nxt  = tx_data;
        busy_nxt  = busy;
        owner_nxt = owner;
        arb       = 1'b0;

        case (state)
            IDLE: begin
                arb = 1'b1;
            end
            ISSUE: begin
                state_nxt = HOLD;
                cnt_nxt   = CNT_W'(FRAME_CYCLES - 1);
                busy_nxt  = 1'b1;
            end
            HOLD: begin
                // The last HOLD cycle doubles as the arbitration point so starts land FRAME_CYCLES apart.
                if (cnt == CNT_W'(1)) begin
                    arb = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase

        if (arb) begin
            cnt_nxt = '0;
            if (any) begin
                state_nxt = ISSUE;
                gnt_nxt   = NUM_REQ'(1) << win_idx;
                start_nxt = 1'b1;
                data_nxt  = words[win_idx];
                owner_nxt = win_idx;
                busy_nxt  = 1'b1;
            end else begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            gnt      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            owner    <= IDX_W'(NUM_REQ - 1);
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            gnt      <= gnt_nxt;
            tx_start <= start_nxt;
            tx_data  <= data_nxt;
            busy     <= busy_nxt;
            owner    <= owner_nxt;
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with a behavioural serial transmitter on its start/data outputs.
// Expected grants are queued when requests are raised and matched when tx_start fires.
module tb_tx_arbiter;

    localparam int NR = 4;

    logic          clk;
    logic          rstn;
    logic [NR-1:0] req;
    logic [NR*7-1:0] req_data;
    logic [NR-1:0] gnt;
    logic          tx_start;
    logic [6:0]    tx_data;
    logic          busy;
    logic [1:0]    owner;

    tx_arbiter #(.NUM_REQ(NR), .FRAME_CYCLES(10)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .busy     (busy),
        .owner    (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter: start, 7 data bits LSB first, even parity, stop; one bit per clock.
    logic [9:0] sh;
    logic [3:0] bitcnt;
    logic       serial_out;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh     <= '1;
            bitcnt <= '0;
        end else if (tx_start) begin
            sh     <= {1'b1, ^tx_data, tx_data, 1'b0};
            bitcnt <= 4'd10;
        end else if (bitcnt != 4'd0) begin
            sh     <= {1'b1, sh[9:1]};
            bitcnt <= bitcnt - 4'd1;
        end
    end
    assign serial_out = (bitcnt != 4'd0) ? sh[0] : 1'b1;

    typedef struct {
        int         idx;
        logic [6:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [9:0] fq[$];
    logic [9:0] frm;
    logic [9:0] last_frame;
    logic       prev_start;
    int         busy_low;
    int         checks   = 0;
    int         failures = 0;
    int         lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input int idx, input logic [6:0] d);
        exp_t e;
        e.idx  = idx;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic set_word(input int i, input logic [6:0] d);
        req_data[i*7 +: 7] = d;
    endtask

    task automatic wait_start(input int max_cyc, output int n);
        bit found;
        found = 1'b0;
        n = 0;
        while (!found && n < max_cyc) begin
            @(negedge clk);
            n++;
            if (tx_start) found = 1'b1;
        end
        checks++;
        assert (found) else begin
            failures++;
            $error("FAIL start_timeout: got no tx_start want one within %0d cycles", max_cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        req  = '0;
        req_data = '0;
        #1;
        sb.delete();
        fq.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Output monitor: scoreboard match on every start, idle checks elsewhere, serial frame capture.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_start = 1'b0;
        end else begin
            if (!busy) busy_low++;
            if (tx_start) begin
                chk("start_back_to_back", 32'(prev_start), 32'd0);
                chk("tx_ready_at_start", 32'(bitcnt <= 4'd1), 32'd1);
                chk("busy_in_issue", 32'(busy), 32'd1);
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_start: got gnt %0h want no start", gnt);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("gnt", 32'(gnt), 32'(1) << e.idx);
                    chk("tx_data", 32'(tx_data), 32'(e.data));
                    chk("owner", 32'(owner), 32'(e.idx));
                    fq.push_back({1'b1, ^e.data, e.data, 1'b0});
                end
            end else begin
                chk("gnt_idle", 32'(gnt), 32'd0);
            end
            if (bitcnt != 4'd0) begin
                frm[4'd10 - bitcnt] = serial_out;
                if (bitcnt == 4'd1) begin
                    last_frame = frm;
                    if (fq.size() != 0) chk("serial_frame", 32'(frm), 32'(fq.pop_front()));
                    else chk("serial_frame_unexpected", 32'(frm), 32'h3ff);
                end
            end
            prev_start = tx_start;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn     = 1'b0;
        req      = '0;
        req_data = '0;
        busy_low = 0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_owner", 32'(owner), 32'd3);
        chk("rst_serial", 32'(serial_out), 32'd1);
        rstn = 1'b1;

        // Single request from idle.
        @(negedge clk);
        set_word(0, 7'h41);
        req = 4'b0001;
        expect_grant(0, 7'h41);
        wait_start(3, lat);
        chk("idle_latency", 32'(lat), 32'd1);
        req = '0;
        repeat (5) @(negedge clk);
        chk("tx_data_hold", 32'(tx_data), 32'h41);
        repeat (4) @(negedge clk);
        chk("busy_last_hold", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_fall", 32'(busy), 32'd0);
        @(negedge clk);
        chk("frame_41", 32'(last_frame), 32'h282);

`ifndef TX_ARB_PRIORITY_EN
        // All four requesting continuously: rotation 0,1,2,3,0 at exact frame spacing.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NR; i++) set_word(i, 7'(i + 1));
        req = 4'b1111;
        for (int i = 0; i < NR; i++) expect_grant(i, 7'(i + 1));
        wait_start(3, lat);
        busy_low = 0;
        set_word(0, 7'h11);
        expect_grant(0, 7'h11);
        for (int k = 0; k < 4; k++) begin
            wait_start(12, lat);
            chk("b2b_spacing", 32'(lat), 32'd10);
        end
        chk("b2b_busy_held", 32'(busy_low), 32'd0);
        req = '0;
        repeat (12) @(negedge clk);
        chk("b2b_idle_busy", 32'(busy), 32'd0);
`endif

        // Parity slot for a word with an odd number of ones.
        @(negedge clk);
        set_word(1, 7'h43);
        req = 4'b0010;
        expect_grant(1, 7'h43);
        wait_start(3, lat);
        req = '0;
        repeat (11) @(negedge clk);
        chk("parity_bit", 32'(last_frame[8]), 32'd1);

        // Withdrawal: req[2] raised and dropped inside HOLD must never be granted.
        @(negedge clk);
        set_word(1, 7'h15);
        req = 4'b0010;
        expect_grant(1, 7'h15);
        wait_start(3, lat);
        req = '0;
        repeat (3) @(negedge clk);
        set_word(2, 7'h22);
        set_word(3, 7'h33);
        req = 4'b1100;
        expect_grant(3, 7'h33);
        repeat (3) @(negedge clk);
        req[2] = 1'b0;
        wait_start(8, lat);
        req = '0;
        repeat (3) @(negedge clk);
        req[2] = 1'b1;
        repeat (3) @(negedge clk);
        req[2] = 1'b0;
        repeat (6) @(negedge clk);
        chk("withdraw_idle_busy", 32'(busy), 32'd0);

        // Reset three cycles into HOLD.
        @(negedge clk);
        set_word(0, 7'h7f);
        req = 4'b0001;
        expect_grant(0, 7'h7f);
        wait_start(3, lat);
        req = '0;
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        #1;
        sb.delete();
        fq.delete();
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
        chk("mid_rst_owner", 32'(owner), 32'd3);
        chk("mid_rst_serial", 32'(serial_out), 32'd1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        set_word(2, 7'h2a);
        req = 4'b0100;
        expect_grant(2, 7'h2a);
        wait_start(3, lat);
        chk("post_rst_latency", 32'(lat), 32'd1);
        req = '0;
        repeat (12) @(negedge clk);

`ifdef TX_ARB_PRIORITY_EN
        // Requester 0 dominates while asking; the rest then rotate 1, 3.
        do_reset();
        @(negedge clk);
        set_word(0, 7'h10);
        set_word(1, 7'h11);
        set_word(3, 7'h13);
        req = 4'b1011;
        for (int k = 0; k < 3; k++) expect_grant(0, 7'h10);
        wait_start(3, lat);
        wait_start(12, lat);
        chk("prio_spacing", 32'(lat), 32'd10);
        wait_start(12, lat);
        req[0] = 1'b0;
        expect_grant(1, 7'h11);
        expect_grant(3, 7'h13);
        wait_start(12, lat);
        req[1] = 1'b0;
        wait_start(12, lat);
        req[3] = 1'b0;
        repeat (12) @(negedge clk);
        chk("prio_idle_busy", 32'(busy), 32'd0);
`endif

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
